count_bcd_display_mux: RTL and testbench
========================================

# count_bcd_display_mux

Downstream consumer of the modulo-100 ascending counter. Samples the 7-bit binary count and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives a time-multiplexed two-digit seven-segment display and flags out-of-range inputs. It sits between the counter's `count_out` and the board display pins.

## Interface
- `WIDTH`, 7, bit width of the binary input (one shift per bit).
- `MAX_VALUE`, 99, largest value displayed numerically; anything above is overflow.
- `SCAN_DIV`, 1000, clock cycles each digit stays selected (must be ≥ 2).

- `clk`  in  1  system clock, rising-edge.
- `async_reset`  in  1  asynchronous, active-high reset.
- `count_in`  in  WIDTH  binary value from the upstream counter.
- `bcd_tens`  out  4  registered tens digit (4'hF on overflow).
- `bcd_units`  out  4  registered units digit (4'hF on overflow).
- `overflow`  out  1  registered; 1 when the last converted value > MAX_VALUE.
- `busy`  out  1  1 while a conversion is in progress.
- `valid`  out  1  one-cycle pulse when the BCD outputs update.
- `seg_out`  out  7  registered segments {g,f,e,d,c,b,a}, active-high.
- `digit_sel`  out  2  registered one-hot enable: 2'b01 = units, 2'b10 = tens.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - If `first_flag` = 1 (set by reset) or `count_in` ≠ `last_val`: load `count_in` into the shift register, clear the BCD scratch, clear `first_flag`, set `busy` = 1, go to CONV.
  - Otherwise stay in IDLE.
- CONV: exactly WIDTH cycles.
  - Each cycle, every scratch nibble ≥ 5 gets +3.
  - Then {scratch, shift} shifts left by 1.
  - After the WIDTH-th shift, go to DONE.
- DONE, one cycle:
  - Set `last_val` to the sampled value.
  - If sampled > MAX_VALUE: `bcd_tens` = `bcd_units` = 4'hF and `overflow` = 1.
  - Else: write the tens and units nibbles and `overflow` = 0.
  - `valid` = 1, `busy` = 0, go to IDLE.
- Changes on `count_in` during CONV or DONE are ignored. The next IDLE cycle compares the current input against `last_val`.
- Scratch is wide enough for the hundreds nibble. For inputs ≤ 99 the hundreds nibble is always 0 and is discarded.
- Scan:
  - `scan_cnt` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the internal select toggles between units and tens.
  - Every cycle, `digit_sel` gets the one-hot select and `seg_out` gets the decode of the selected digit register.
- Decode: 0→7'h3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, 4'hF→40 (dash). All other codes → 00 (blank).

## Timing
- Reset values:
  - `bcd_tens`, `bcd_units`, `overflow`, `busy`, `valid` = 0.
  - `seg_out` = 7'h00, `digit_sel` = 2'b00.
  - State IDLE, `scan_cnt` = 0, select = units, `first_flag` = 1, `last_val` = 0.
- Latency:
  - Sampling edge E (leaving IDLE) → BCD outputs and `valid` are visible after edge E+WIDTH+1.
  - That is 8 cycles at WIDTH = 7.
- Throughput: at most one conversion per WIDTH+2 cycles (9), because one IDLE cycle is needed before the next sample.
- `busy` is high from edge E through edge E+WIDTH, and low in the cycle `valid` is high.
- `seg_out` and `digit_sel` change on the same edge. A BCD update reaches `seg_out` one cycle after `valid`.
- Digit period = SCAN_DIV cycles. Full display refresh = 2·SCAN_DIV cycles.
- Reset asserted mid-conversion: all registers return to reset values immediately and the conversion is aborted. After release, the first IDLE cycle reconverts via `first_flag`.
- Wrap 99→0 is an ordinary value change; no special handling.

## Configuration
- Macro: `COUNT_BCD_BLANK_LEADING_ZERO_EN`.
  - Defined: when the tens digit is 0 and `overflow` = 0, `seg_out` = 7'h00 while `digit_sel` = 2'b10. Units display normally, including value 0.
  - Undefined: tens digit 0 shows 7'h3F.
  - In both builds, `bcd_tens` carries the true digit.

## Test plan
- Reset release with `count_in` = 0 → `valid` pulse 8 cycles after the first edge; `bcd_tens` = 0, `bcd_units` = 0, `overflow` = 0. No further `valid` while the input is held.
- `count_in` = 47 held, SCAN_DIV = 4 → `digit_sel` 01/`seg_out` 07 and 10/66 alternate every 4 cycles.
  - With `COUNT_BCD_BLANK_LEADING_ZERO_EN` and `count_in` = 7: tens phase `seg_out` = 00.
- `count_in` 99 then 0 → results 9/9 and then 0/0, each with a single `valid` pulse and `overflow` = 0.
- `count_in` = 115 → `overflow` = 1, both digits 4'hF, `seg_out` = 40 in both phases. Returning to 12 clears `overflow` with digits 1/2.
- Driven by the modulo-100 counter (changes every cycle) → every `valid` result equals the `count_in` sampled at its start edge. A scoreboard checks all conversions over 300 cycles.
- `async_reset` pulsed 3 cycles into CONV → outputs zero asynchronously and `busy` = 0. After release, a full reconversion of the current input completes in 8 cycles.

Source files
------------

// File: rtl/count_bcd_display_mux.sv
// Binary-to-BCD converter (sequential double-dabble) driving a two-digit multiplexed 7-segment display.
// Optional macro COUNT_BCD_BLANK_LEADING_ZERO_EN blanks a leading zero tens digit.
module count_bcd_display_mux #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MAX_VALUE = 99,
  parameter int unsigned SCAN_DIV  = 1000
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [WIDTH-1:0] count_in,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic             overflow,
  output logic             busy,
  output logic             valid,
  output logic [6:0]       seg_out,
  output logic [1:0]       digit_sel
);

  // Scratch holds every decimal digit of the widest input (at least tens and units).
  localparam int unsigned NIB    = ((WIDTH + 2) / 3 > 2) ? (WIDTH + 2) / 3 : 2;
  localparam int unsigned SCR_W  = 4 * NIB;
  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   shift, shift_d;
  logic [WIDTH-1:0]   sample, sample_d;
  logic [WIDTH-1:0]   last_val, last_val_d;
  logic [SCR_W-1:0]   scratch, scratch_d, adj;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic               first_flag, first_flag_d;
  logic [3:0]         tens_d, units_d;
  logic               overflow_d, busy_d, valid_d;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               sel;
  logic [6:0]         seg_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h07;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h6F;
      4'hF:    seg_decode = 7'h40;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) state <= IDLE;
    else             state <= state_d;
  end

  // Next state and datapath: sample in IDLE, add-3/shift in CONV, publish in DONE.
  always_comb begin
    state_d      = state;
    shift_d      = shift;
    sample_d     = sample;
    last_val_d   = last_val;
    scratch_d    = scratch;
    bit_cnt_d    = bit_cnt;
    first_flag_d = first_flag;
    tens_d       = bcd_tens;
    units_d      = bcd_units;
    overflow_d   = overflow;
    busy_d       = busy;
    valid_d      = 1'b0;
    adj          = scratch;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    unique case (state)
      IDLE: begin
        if (first_flag || (count_in != last_val)) begin
          shift_d      = count_in;
          sample_d     = count_in;
          scratch_d    = '0;
          bit_cnt_d    = '0;
          first_flag_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = CONV;
        end
      end
      CONV: begin
        scratch_d = {adj[SCR_W-2:0], shift[WIDTH-1]};
        shift_d   = {shift[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        last_val_d = sample;
        if (sample > MAX_V) begin
          tens_d     = 4'hF;
          units_d    = 4'hF;
          overflow_d = 1'b1;
        end else begin
          tens_d     = scratch[7:4];
          units_d    = scratch[3:0];
          overflow_d = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      shift      <= '0;
      sample     <= '0;
      last_val   <= '0;
      scratch    <= '0;
      bit_cnt    <= '0;
      first_flag <= 1'b1;
      bcd_tens   <= 4'h0;
      bcd_units  <= 4'h0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      shift      <= shift_d;
      sample     <= sample_d;
      last_val   <= last_val_d;
      scratch    <= scratch_d;
      bit_cnt    <= bit_cnt_d;
      first_flag <= first_flag_d;
      bcd_tens   <= tens_d;
      bcd_units  <= units_d;
      overflow   <= overflow_d;
      busy       <= busy_d;
      valid      <= valid_d;
    end
  end

  // Segment pattern for the currently selected digit.
  always_comb begin
    seg_c = seg_decode(sel ? bcd_tens : bcd_units);
`ifdef COUNT_BCD_BLANK_LEADING_ZERO_EN
    if (sel && (bcd_tens == 4'h0) && !overflow) seg_c = 7'h00;
`endif
  end

  // Display scan: sel = 0 units, 1 tens; toggles every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      scan_cnt  <= '0;
      sel       <= 1'b0;
      seg_out   <= 7'h00;
      digit_sel <= 2'b00;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      digit_sel <= sel ? 2'b10 : 2'b01;
      seg_out   <= seg_c;
    end
  end

endmodule

// File: tb/tb_count_bcd_display_mux.sv
// Directed self-checking bench for count_bcd_display_mux (SCAN_DIV shortened to 4).
module tb_count_bcd_display_mux;

  localparam int unsigned WIDTH    = 7;
  localparam int unsigned SCAN_DIV = 4;

`ifdef COUNT_BCD_BLANK_LEADING_ZERO_EN
  localparam logic [6:0] TENS0_SEG = 7'h00;
`else
  localparam logic [6:0] TENS0_SEG = 7'h3F;
`endif

  logic             clk = 1'b0;
  logic             async_reset;
  logic [WIDTH-1:0] count_in;
  logic [3:0]       bcd_tens, bcd_units;
  logic             overflow, busy, valid;
  logic [6:0]       seg_out;
  logic [1:0]       digit_sel;

  int checks = 0;
  int errors = 0;
  int hist[300];

  count_bcd_display_mux #(
    .WIDTH(WIDTH), .MAX_VALUE(99), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .async_reset(async_reset), .count_in(count_in),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units), .overflow(overflow),
    .busy(busy), .valid(valid), .seg_out(seg_out), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic convert(input string tag, input int v, input int tens, input int units, input int ovf);
    bit ok;
    count_in = 7'(v);
    wait_valid(20, ok);
    check({tag, "_valid"}, 32'(ok), 32'd1);
    check({tag, "_tens"}, 32'(bcd_tens), 32'(tens));
    check({tag, "_units"}, 32'(bcd_units), 32'(units));
    check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic no_valid(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (valid !== 1'b0) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  task automatic scan_check(input string tag, input logic [6:0] useg, input logic [6:0] tseg);
    logic [1:0] prev, first, es;
    bit found;
    tick();
    prev  = digit_sel;
    found = 1'b0;
    for (int i = 0; i < 2 * int'(SCAN_DIV) && !found; i++) begin
      tick();
      if (digit_sel !== prev) found = 1'b1;
    end
    check({tag, "_phase_edge"}, 32'(found), 32'd1);
    first = digit_sel;
    for (int k = 0; k < 4 * int'(SCAN_DIV); k++) begin
      es = (((k / int'(SCAN_DIV)) % 2) == 0) ? first : ~first;
      check({tag, "_sel"}, 32'(digit_sel), 32'(es));
      check({tag, "_seg"}, 32'(seg_out), 32'((es == 2'b01) ? useg : tseg));
      tick();
    end
  endtask

  initial begin
    bit ok;
    int v, nval, last_i;

    // Reset state
    async_reset = 1'b1;
    count_in    = '0;
    repeat (3) tick();
    check("rst_tens", 32'(bcd_tens), 32'd0);
    check("rst_units", 32'(bcd_units), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_seg", 32'(seg_out), 32'h00);
    check("rst_dsel", 32'(digit_sel), 32'd0);

    // First conversion after release: valid after the 9th edge (E+8)
    async_reset = 1'b0;
    tick();
    check("first_busy_e", 32'(busy), 32'd1);
    check("first_valid_e", 32'(valid), 32'd0);
    repeat (7) tick();
    check("first_busy_e7", 32'(busy), 32'd1);
    check("first_valid_e7", 32'(valid), 32'd0);
    tick();
    check("first_valid", 32'(valid), 32'd1);
    check("first_busy_done", 32'(busy), 32'd0);
    check("first_tens", 32'(bcd_tens), 32'd0);
    check("first_units", 32'(bcd_units), 32'd0);
    check("first_ovf", 32'(overflow), 32'd0);
    no_valid("first_hold_no_valid", 20);

    // Display scan
    convert("v47", 47, 4, 7, 0);
    scan_check("scan47", 7'h07, 7'h66);
    convert("v7", 7, 0, 7, 0);
    scan_check("scan7", 7'h07, TENS0_SEG);

    // 99 then wrap to 0
    convert("v99", 99, 9, 9, 0);
    no_valid("v99_single", 6);
    convert("v0", 0, 0, 0, 0);
    no_valid("v0_single", 6);

    // Overflow and recovery
    convert("v115", 115, 15, 15, 1);
    tick();
    for (int i = 0; i < 4 * int'(SCAN_DIV); i++) begin
      check("ovf_seg", 32'(seg_out), 32'h40);
      tick();
    end
    convert("v12", 12, 1, 2, 0);

    // Upstream counter stepping every cycle: result equals input at sample edge
    v = 50; nval = 0; last_i = -1;
    for (int i = 0; i < 300; i++) begin
      count_in = 7'(v);
      hist[i]  = v;
      tick();
      if (valid === 1'b1) begin
        nval++;
        if (i >= 8) begin
          check("sb_tens", 32'(bcd_tens), 32'(hist[i-8] / 10));
          check("sb_units", 32'(bcd_units), 32'(hist[i-8] % 10));
          check("sb_ovf", 32'(overflow), 32'd0);
        end else begin
          check("sb_early_valid", 32'(i), 32'd8);
        end
        if (last_i >= 0) check("sb_spacing", 32'(i - last_i), 32'd9);
        last_i = i;
      end
      v = (v + 1) % 100;
    end
    check("sb_count", 32'(nval), 32'd33);
    wait_valid(20, ok);
    check("sb_drain", 32'(ok), 32'd1);

    // Reset three cycles into a conversion, then full reconversion
    count_in = 7'd63;
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    async_reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tens", 32'(bcd_tens), 32'd0);
    check("mid_rst_units", 32'(bcd_units), 32'd0);
    check("mid_rst_seg", 32'(seg_out), 32'h00);
    check("mid_rst_dsel", 32'(digit_sel), 32'd0);
    tick();
    async_reset = 1'b0;
    tick();
    check("re_busy", 32'(busy), 32'd1);
    repeat (7) tick();
    check("re_valid_early", 32'(valid), 32'd0);
    tick();
    check("re_valid", 32'(valid), 32'd1);
    check("re_tens", 32'(bcd_tens), 32'd6);
    check("re_units", 32'(bcd_units), 32'd3);
    check("re_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
